// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port shared by data_mem_arbiter.
// master = arbiter side, slave = requesters plus memory model.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Handshake: a requester raises req with we/addr/wdata stable and keeps it high until it
    // samples ack = 1 (one-cycle pulse); rdata is valid from the cycle after a read's ack.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port (CPU / DMA) arbiter and access sequencer for the 8-bit data memory.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed CPU priority.
module data_mem_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_arbiter_if.master   bus,
    output logic [1:0]           state_dbg,
    output logic                 last_grant_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              last_grant;
    logic              grant;
    logic              win;
    logic              start;
    logic              we_lat;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] wdata_lat;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        win       = PORT_CPU;
        if (bus.cpu_req && bus.dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = ~last_grant;
`else
            win = PORT_CPU;
`endif
        end else if (bus.dma_req) begin
            win = PORT_DMA;
        end
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Requester inputs are captured only at grant; later changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_grant  <= PORT_DMA;
            grant       <= PORT_CPU;
            we_lat      <= 1'b0;
            addr_lat    <= '0;
            wdata_lat   <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                grant      <= win;
                last_grant <= win;
                we_lat     <= win ? bus.dma_we    : bus.cpu_we;
                addr_lat   <= win ? bus.dma_addr  : bus.cpu_addr;
                wdata_lat  <= win ? bus.dma_wdata : bus.cpu_wdata;
                cnt        <= 4'(ACCESS_CYCLES - 1);
            end else if (state == ACCESS) begin
                if (cnt == 4'd0) begin
                    if (!we_lat) begin
                        if (grant == PORT_CPU) cpu_rdata_q <= bus.mem_rdata;
                        else                   dma_rdata_q <= bus.mem_rdata;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        bus.mem_read   = (state == ACCESS) && !we_lat;
        bus.mem_write  = (state == ACCESS) && we_lat;
        bus.mem_addr   = (state == ACCESS) ? addr_lat  : '0;
        bus.mem_wdata  = (state == ACCESS) ? wdata_lat : '0;
        bus.cpu_ack    = (state == RESP) && (grant == PORT_CPU);
        bus.dma_ack    = (state == RESP) && (grant == PORT_DMA);
        bus.cpu_stall  = bus.cpu_req && !bus.cpu_ack;
        bus.cpu_rdata  = cpu_rdata_q;
        bus.dma_rdata  = dma_rdata_q;
        state_dbg      = state;
        last_grant_dbg = last_grant;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter (default ACCESS_CYCLES = 2).
// Expected winners follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_data_mem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;
    logic       last_grant_dbg;
    int         checks = 0;
    int         errors = 0;

    data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.master),
        .state_dbg      (state_dbg),
        .last_grant_dbg (last_grant_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 8'h00; bus.dma_wdata = 8'h00;
        bus.mem_rdata = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
        bus.cpu_addr = 8'h11; bus.dma_addr = 8'h22; bus.mem_rdata = 8'h77;
        #1;
        checks++;
        if ({bus.cpu_ack, bus.dma_ack, bus.mem_read, bus.mem_write} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 0000",
                               {bus.cpu_ack, bus.dma_ack, bus.mem_read, bus.mem_write});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_mem_bus: got %h expected 0000", {bus.mem_addr, bus.mem_wdata});
        end
        checks++;
        if ({bus.cpu_rdata, bus.dma_rdata} !== 16'h0000) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0000", {bus.cpu_rdata, bus.dma_rdata});
        end
        checks++;
        if (bus.cpu_stall !== 1'b1) begin
            errors++; $display("FAIL reset_stall: got %b expected 1", bus.cpu_stall);
        end
        checks++;
        if ({state_dbg, last_grant_dbg} !== 3'b001) begin
            errors++; $display("FAIL reset_state: got %b expected 001", {state_dbg, last_grant_dbg});
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h11) begin
            errors++; $display("FAIL first_grant_cpu: got rd=%b addr=%h expected rd=1 addr=11",
                               bus.mem_read, bus.mem_addr);
        end
        tick();
        tick();
        checks++;
        if ({bus.cpu_ack, bus.dma_ack} !== 2'b10) begin
            errors++; $display("FAIL first_grant_ack: got %b expected 10", {bus.cpu_ack, bus.dma_ack});
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_rdata !== 8'h77) begin
            errors++; $display("FAIL first_grant_rdata: got %h expected 77", bus.cpu_rdata);
        end
    endtask

    task automatic test_cpu_read();
        logic [2:0] exp_rd;
        logic [2:0] exp_ack;
        logic [2:0] exp_stall;
        logic [7:0] exp_addr [3];
        exp_rd = 3'b011; exp_ack = 3'b100; exp_stall = 3'b011;
        exp_addr[0] = 8'h10; exp_addr[1] = 8'h10; exp_addr[2] = 8'h00;
        apply_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h10; bus.mem_rdata = 8'h5A;
        #1;
        checks++;
        if (bus.cpu_stall !== 1'b1) begin
            errors++; $display("FAIL rd_stall_c0: got %b expected 1", bus.cpu_stall);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.mem_read !== exp_rd[c] || bus.mem_write !== 1'b0 || bus.mem_addr !== exp_addr[c]) begin
                errors++; $display("FAIL rd_mem_c%0d: got rd=%b wr=%b addr=%h expected rd=%b wr=0 addr=%h",
                                   c + 1, bus.mem_read, bus.mem_write, bus.mem_addr, exp_rd[c], exp_addr[c]);
            end
            checks++;
            if (bus.cpu_ack !== exp_ack[c] || bus.cpu_stall !== exp_stall[c] || bus.dma_ack !== 1'b0) begin
                errors++; $display("FAIL rd_ack_c%0d: got ack=%b stall=%b dack=%b expected ack=%b stall=%b dack=0",
                                   c + 1, bus.cpu_ack, bus.cpu_stall, bus.dma_ack, exp_ack[c], exp_stall[c]);
            end
        end
        bus.cpu_req = 1'b0;
        tick();
        checks++;
        if (bus.cpu_rdata !== 8'h5A || bus.cpu_ack !== 1'b0) begin
            errors++; $display("FAIL rd_data_c4: got rdata=%h ack=%b expected rdata=5a ack=0",
                               bus.cpu_rdata, bus.cpu_ack);
        end
    endtask

    task automatic test_dma_write();
        int wr_cycles;
        int ack_cycles;
        wr_cycles = 0;
        ack_cycles = 0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h20; bus.dma_wdata = 8'hC3;
        bus.mem_rdata = 8'hEE;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (bus.mem_write === 1'b1) begin
                wr_cycles++;
                checks++;
                if (bus.mem_addr !== 8'h20 || bus.mem_wdata !== 8'hC3 || bus.mem_read !== 1'b0) begin
                    errors++; $display("FAIL wr_bus_c%0d: got addr=%h data=%h rd=%b expected 20 c3 0",
                                       c, bus.mem_addr, bus.mem_wdata, bus.mem_read);
                end
            end
            if (bus.dma_ack === 1'b1) begin
                ack_cycles++;
                bus.dma_req = 1'b0;
            end
        end
        checks++;
        if (wr_cycles != 2 || ack_cycles != 1) begin
            errors++; $display("FAIL wr_counts: got wr=%0d ack=%0d expected wr=2 ack=1", wr_cycles, ack_cycles);
        end
        checks++;
        if (bus.dma_rdata !== 8'h00 || bus.cpu_rdata !== 8'h5A) begin
            errors++; $display("FAIL wr_rdata_hold: got dma=%h cpu=%h expected dma=00 cpu=5a",
                               bus.dma_rdata, bus.cpu_rdata);
        end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_win;
        int dma_acks;
`ifdef ARB_ROUND_ROBIN_EN
        exp_win = 4'b1010;
`else
        exp_win = 4'b0000;
`endif
        dma_acks = 0;
        apply_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h30;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40;
        bus.mem_rdata = 8'h99;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (bus.mem_addr !== (exp_win[t] ? 8'h40 : 8'h30)) begin
                errors++; $display("FAIL arb_addr_t%0d: got %h expected %h",
                                   t, bus.mem_addr, exp_win[t] ? 8'h40 : 8'h30);
            end
            tick();
            tick();
            checks++;
            if ({bus.cpu_ack, bus.dma_ack} !== (exp_win[t] ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL arb_ack_t%0d: got %b expected %b",
                                   t, {bus.cpu_ack, bus.dma_ack}, exp_win[t] ? 2'b01 : 2'b10);
            end
            if (bus.dma_ack === 1'b1) dma_acks++;
            tick();
        end
        checks++;
        if (dma_acks != (exp_win[0] + exp_win[1] + exp_win[2] + exp_win[3])) begin
            errors++; $display("FAIL arb_dma_acks: got %0d expected %0d",
                               dma_acks, exp_win[0] + exp_win[1] + exp_win[2] + exp_win[3]);
        end
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h50; bus.cpu_wdata = 8'hA5;
        tick();
        tick();
        checks++;
        if (bus.mem_write !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre: got wr=%b expected 1", bus.mem_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0 || bus.cpu_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_drop: got wr=%b ack=%b expected 0 0", bus.mem_write, bus.cpu_ack);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (bus.cpu_ack !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL rst_mid_noack: got ack=%b wr=%b expected 0 0", bus.cpu_ack, bus.mem_write);
        end
        tick();
        tick();
        checks++;
        if (bus.mem_write !== 1'b1 || bus.mem_addr !== 8'h50 || bus.mem_wdata !== 8'hA5) begin
            errors++; $display("FAIL rst_mid_regrant: got wr=%b addr=%h data=%h expected 1 50 a5",
                               bus.mem_write, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.mem_write !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ack: got ack=%b wr=%b expected 1 0", bus.cpu_ack, bus.mem_write);
        end
        bus.cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_req_drop();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h60; bus.mem_rdata = 8'h3C;
        tick();
        bus.cpu_req = 1'b0; bus.cpu_addr = 8'hFF; bus.cpu_we = 1'b1;
        #1;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 8'h60) begin
            errors++; $display("FAIL drop_c1: got rd=%b addr=%h expected 1 60", bus.mem_read, bus.mem_addr);
        end
        tick();
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_addr !== 8'h60) begin
            errors++; $display("FAIL drop_c2: got rd=%b wr=%b addr=%h expected 1 0 60",
                               bus.mem_read, bus.mem_write, bus.mem_addr);
        end
        tick();
        checks++;
        if (bus.cpu_ack !== 1'b1 || bus.mem_read !== 1'b0) begin
            errors++; $display("FAIL drop_ack: got ack=%b rd=%b expected 1 0", bus.cpu_ack, bus.mem_read);
        end
        tick();
        checks++;
        if (bus.cpu_rdata !== 8'h3C || bus.cpu_ack !== 1'b0 || state_dbg !== 2'd0) begin
            errors++; $display("FAIL drop_rdata: got rdata=%h ack=%b state=%0d expected 3c 0 0",
                               bus.cpu_rdata, bus.cpu_ack, state_dbg);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_arbitration();
        test_reset_mid_access();
        test_req_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
